// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared, registered ALU (1-cycle latency).
// Round-robin grant, one op in flight, and one parked response slot per
// requester that holds its result until that requester consumes it.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic [INST_WIDTH-1:0] i_req0_inst,

  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  input  logic [INST_WIDTH-1:0] i_req1_inst,

  output logic                  o_resp0_valid,
  input  logic                  i_resp0_ready,
  output logic [DATA_WIDTH-1:0] o_resp0_data,
  output logic                  o_resp0_overflow,

  output logic                  o_resp1_valid,
  input  logic                  i_resp1_ready,
  output logic [DATA_WIDTH-1:0] o_resp1_data,
  output logic                  o_resp1_overflow,

  output logic                  o_alu_valid,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [INST_WIDTH-1:0] o_alu_inst,
  input  logic                  i_alu_valid,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic                  i_alu_overflow
);

  logic                       inflight_valid_q, inflight_valid_d;
  logic                       inflight_id_q, inflight_id_d;
  logic                       last_grant_q, last_grant_d;
  logic [1:0]                 resp_valid_q, resp_valid_d;
  logic [1:0][DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [1:0]                 resp_ovf_q, resp_ovf_d;

  logic [1:0] req_valid;
  logic [1:0] resp_ready;
  logic [1:0] busy;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] complete;

  assign req_valid  = {i_req1_valid, i_req0_valid};
  assign resp_ready = {i_resp1_ready, i_resp0_ready};

  // A requester is busy while its op is in flight or its slot is full and not draining.
  always_comb begin
    busy[0]     = (inflight_valid_q && !inflight_id_q) || (resp_valid_q[0] && !resp_ready[0]);
    busy[1]     = (inflight_valid_q &&  inflight_id_q) || (resp_valid_q[1] && !resp_ready[1]);
    eligible    = req_valid & ~busy;
    complete[0] = i_alu_valid && inflight_valid_q && !inflight_id_q;
    complete[1] = i_alu_valid && inflight_valid_q &&  inflight_id_q;
  end

  // Round-robin grant; no ops are accepted while reset is asserted.
  always_comb begin
    grant = 2'b00;
    if (!i_rst) begin
      unique case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];

  // Operand mux toward the ALU; zeros when idle.
  always_comb begin
    o_alu_valid = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_inst  = '0;
    unique case (grant)
      2'b01: begin
        o_alu_valid = 1'b1;
        o_alu_a     = i_req0_a;
        o_alu_b     = i_req0_b;
        o_alu_inst  = i_req0_inst;
      end
      2'b10: begin
        o_alu_valid = 1'b1;
        o_alu_a     = i_req1_a;
        o_alu_b     = i_req1_b;
        o_alu_inst  = i_req1_inst;
      end
      default: ;
    endcase
  end

  // In-flight tracking and round-robin pointer.
  always_comb begin
    inflight_valid_d = |grant;
    inflight_id_d    = inflight_id_q;
    last_grant_d     = last_grant_q;
    if (|grant) begin
      inflight_id_d = grant[1];
      last_grant_d  = grant[1];
    end
  end

  // Response slots: consume clears, a completion for the same slot overrides the clear.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_ovf_d   = resp_ovf_q;
    for (int k = 0; k < 2; k++) begin
      if (resp_valid_q[k] && resp_ready[k]) begin
        resp_valid_d[k] = 1'b0;
      end
      if (complete[k]) begin
        resp_valid_d[k] = 1'b1;
        resp_data_d[k]  = i_alu_data;
        resp_ovf_d[k]   = i_alu_overflow;
      end
    end
  end

  // State registers with synchronous reset; reset drops any in-flight result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight_valid_q <= 1'b0;
      inflight_id_q    <= 1'b0;
      last_grant_q     <= 1'b1;
      resp_valid_q     <= '0;
      resp_data_q      <= '0;
      resp_ovf_q       <= '0;
    end else begin
      inflight_valid_q <= inflight_valid_d;
      inflight_id_q    <= inflight_id_d;
      last_grant_q     <= last_grant_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_ovf_q       <= resp_ovf_d;
    end
  end

  assign o_resp0_valid    = resp_valid_q[0];
  assign o_resp0_data     = resp_data_q[0];
  assign o_resp0_overflow = resp_ovf_q[0];
  assign o_resp1_valid    = resp_valid_q[1];
  assign o_resp1_data     = resp_data_q[1];
  assign o_resp1_overflow = resp_ovf_q[1];

endmodule
